// File: rtl/pwm_decoder.sv
// PWM input measurement: high time and rising-to-rising period in clk cycles,
// with a one-cycle valid per completed period and a loss-of-signal flag.
module pwm_decoder #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 2500000,
  parameter int MIN_W   = 100000,
  parameter int MAX_W   = 200000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] period_count,
  output logic             valid,
  output logic             in_range,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LO_W = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] HI_W = CNT_W'(MAX_W);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_d;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] hcnt, pcnt, hcnt_d, pcnt_d;
  logic             latch, tmo_set, tmo_clr;

  // Counters stop at the timeout value so they can never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v < TMO))
      return v + ONE;
    return v;
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] v);
    return (v >= LO_W) && (v <= HI_W);
  endfunction

  // Stage: synchronizer (s1,s2) and edge-detect delay (s3)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_comb begin
    state_d = state;
    hcnt_d  = hcnt;
    pcnt_d  = pcnt;
    latch   = 1'b0;
    tmo_set = 1'b0;
    tmo_clr = 1'b0;
    if (!en) begin
      state_d = IDLE;
      hcnt_d  = '0;
      pcnt_d  = '0;
    end else begin
      case (state)
        IDLE: begin
          hcnt_d = '0;
          pcnt_d = '0;
          if (rise) begin
            hcnt_d  = ONE;
            pcnt_d  = ONE;
            tmo_clr = 1'b1;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (pcnt >= TMO) begin
            tmo_set = 1'b1;
            hcnt_d  = '0;
            pcnt_d  = '0;
            state_d = IDLE;
          end else begin
            hcnt_d = sat_inc(hcnt, s2);
            pcnt_d = sat_inc(pcnt, 1'b1);
            if (fall)
              state_d = LOW;
          end
        end
        LOW: begin
          // A rise in the same cycle as saturation still yields a result.
          if (rise) begin
            latch   = 1'b1;
            hcnt_d  = ONE;
            pcnt_d  = ONE;
            state_d = HIGH;
          end else if (pcnt >= TMO) begin
            tmo_set = 1'b1;
            hcnt_d  = '0;
            pcnt_d  = '0;
            state_d = IDLE;
          end else begin
            pcnt_d = sat_inc(pcnt, 1'b1);
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
          pcnt_d  = '0;
        end
      endcase
    end
  end

  // Stage: measurement state and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      hcnt  <= '0;
      pcnt  <= '0;
    end else begin
      state <= state_d;
      hcnt  <= hcnt_d;
      pcnt  <= pcnt_d;
    end
  end

  // Stage: result snapshot, held until the next completed period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_count   <= '0;
      period_count <= '0;
      in_range     <= 1'b0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      valid <= latch;
      if (latch) begin
        high_count   <= hcnt;
        period_count <= pcnt;
        in_range     <= in_window(hcnt);
      end
      if (tmo_set)
        timeout <= 1'b1;
      else if (tmo_clr)
        timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: table of PWM segments plus hand sequences
// for timeout, asynchronous reset and enable gaps.
module tb_pwm_decoder;

  localparam int CNT_W = 32;
  localparam int TMO   = 5000;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_count, period_count;
  logic             valid, in_range, timeout;

  pwm_decoder #(.CNT_W(CNT_W), .TIMEOUT(TMO), .MIN_W(100), .MAX_W(200)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .pwm_in(pwm_in),
    .high_count(high_count), .period_count(period_count),
    .valid(valid), .in_range(in_range), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   nval = 0;
  int   vedge = -1;
  int   to_edge = -1;
  int   last_rise = 0;
  logic prev_valid = 1'b0;
  logic prev_to = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edge monitor: cyc is the index of the clk edge just passed.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (valid) begin
      chk("valid_not_back_to_back", {63'd0, prev_valid}, 64'd0);
      nval++;
      vedge = cyc;
    end
    if (timeout && !prev_to)
      to_edge = cyc;
    prev_valid = valid;
    prev_to    = timeout;
  end

  task automatic hold(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Driven at a negedge: sampled next edge, rise seen three edges later.
  task automatic pulse(input int h, input int p);
    last_rise = cyc + 3;
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  typedef struct {
    int h;
    int p;
    int n;
    int exp_nv;
    int exp_h;
    int exp_p;
    bit exp_inr;
  } vec_t;

  vec_t tab[10];

  initial begin
    tab[0] = '{150, 1000, 3, 2, 150, 1000, 1'b1};
    tab[1] = '{ 50, 1000, 2, 2,  50, 1000, 1'b0};
    tab[2] = '{100, 1000, 2, 2, 100, 1000, 1'b1};
    tab[3] = '{200, 1000, 2, 2, 200, 1000, 1'b1};
    tab[4] = '{201, 1000, 2, 2, 201, 1000, 1'b0};
    tab[5] = '{ 99, 1000, 2, 2,  99, 1000, 1'b0};
    tab[6] = '{  1, 1000, 2, 2,   1, 1000, 1'b0};
    tab[7] = '{150, 5000, 2, 2, 150, 5000, 1'b1};
    tab[8] = '{180,  500, 2, 2, 180,  500, 1'b1};
    tab[9] = '{ 50, 1000, 2, 2,  50, 1000, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_high_count", high_count, 0);
    chk("rst_period_count", period_count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_in_range", in_range, 0);
    chk("rst_timeout", timeout, 0);
    reset_n = 1'b1;
    en = 1'b1;
    hold(1'b0, 5);

    for (int i = 0; i < 10; i++) begin
      nval = 0;
      repeat (tab[i].n) pulse(tab[i].h, tab[i].p);
      chk($sformatf("vec%0d_nvalid", i), nval, tab[i].exp_nv);
      chk($sformatf("vec%0d_valid_edge", i), vedge, last_rise);
      chk($sformatf("vec%0d_high", i), high_count, tab[i].exp_h);
      chk($sformatf("vec%0d_period", i), period_count, tab[i].exp_p);
      chk($sformatf("vec%0d_in_range", i), in_range, tab[i].exp_inr);
      chk($sformatf("vec%0d_timeout", i), timeout, 0);
    end

    // Stuck low after a period
    to_edge = -1;
    nval = 0;
    hold(1'b0, 6000);
    chk("lo_timeout_edge", to_edge, last_rise + TMO);
    chk("lo_timeout", timeout, 1);
    chk("lo_nvalid", nval, 0);
    chk("lo_high_hold", high_count, 50);
    chk("lo_period_hold", period_count, 1000);
    chk("lo_in_range_hold", in_range, 0);
    nval = 0;
    last_rise = cyc + 3;
    hold(1'b1, 4);
    chk("lo_timeout_cleared", timeout, 0);
    hold(1'b1, 146);
    hold(1'b0, 850);
    chk("lo_resume_first_nvalid", nval, 0);
    pulse(150, 1000);
    chk("lo_resume_nvalid", nval, 1);
    chk("lo_resume_valid_edge", vedge, last_rise);
    chk("lo_resume_high", high_count, 150);
    chk("lo_resume_period", period_count, 1000);

    // Stuck high: the opening rise completes the prior period, then nothing
    to_edge = -1;
    nval = 0;
    last_rise = cyc + 3;
    hold(1'b1, 6000);
    chk("hi_timeout_edge", to_edge, last_rise + TMO);
    chk("hi_timeout", timeout, 1);
    chk("hi_nvalid", nval, 1);
    chk("hi_valid_edge", vedge, last_rise);
    chk("hi_high_hold", high_count, 150);
    hold(1'b0, 200);

    // Asynchronous reset mid-HIGH
    nval = 0;
    pulse(150, 1000);
    pulse(150, 1000);
    chk("ar_pre_nvalid", nval, 1);
    chk("ar_pre_high", high_count, 150);
    hold(1'b1, 50);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_high_count", high_count, 0);
    chk("ar_period_count", period_count, 0);
    chk("ar_valid", valid, 0);
    chk("ar_in_range", in_range, 0);
    chk("ar_timeout", timeout, 0);
    hold(1'b0, 3);
    reset_n = 1'b1;
    hold(1'b0, 10);
    nval = 0;
    pulse(150, 1000);
    chk("ar_first_nvalid", nval, 0);
    pulse(150, 1000);
    chk("ar_nvalid", nval, 1);
    chk("ar_valid_edge", vedge, last_rise);
    chk("ar_high", high_count, 150);
    chk("ar_period", period_count, 1000);

    // Enable dropped mid-LOW
    pulse(150, 1000);
    hold(1'b1, 150);
    hold(1'b0, 200);
    en = 1'b0;
    nval = 0;
    hold(1'b0, 300);
    chk("en_off_nvalid", nval, 0);
    en = 1'b1;
    hold(1'b0, 350);
    chk("en_high_hold", high_count, 150);
    chk("en_period_hold", period_count, 1000);
    chk("en_in_range_hold", in_range, 1);
    chk("en_timeout_hold", timeout, 0);
    nval = 0;
    pulse(150, 1000);
    chk("en_discard_nvalid", nval, 0);
    pulse(150, 1000);
    chk("en_nvalid", nval, 1);
    chk("en_valid_edge", vedge, last_rise);
    chk("en_period", period_count, 1000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
